// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bus bundle for reg_file_sb (write, two reads, reserve, clear)
// master drives requests and addresses; slave returns read data, pending bits and busy.
interface reg_file_sb_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [AW-1:0] r_addr1;
  logic [AW-1:0] r_addr2;
  logic [DW-1:0] r_data1;
  logic [DW-1:0] r_data2;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          pend1;
  logic          pend2;
  logic          clr_req;
  logic          busy;
  modport master (
    output we, w_addr, w_data, r_addr1, r_addr2, rsv_en, rsv_addr, clr_req,
    input  r_data1, r_data2, pend1, pend2, busy
  );
  modport slave (
    input  we, w_addr, w_data, r_addr1, r_addr2, rsv_en, rsv_addr, clr_req,
    output r_data1, r_data2, pend1, pend2, busy
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write bypass, pending scoreboard and clear sweep
// Ports: clk, rst (async, active-high); bus (slave) carries write port, two
// combinational read ports with pending bits, reserve request, clear request and busy.
module reg_file_sb #(
  parameter int DW      = 16,
  parameter int DEPTH   = 16,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t         state_q, state_d;
  logic [AW-1:0]  cnt_q;
  logic [DW-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic           idle, wr_ok, rsv_ok;
  // Out-of-range addresses and a hardwired R0 are never written, reserved or read.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !(ZERO_R0 && a == '0);
  endfunction
  assign idle   = state_q == IDLE;
  assign wr_ok  = idle && bus.we && addr_ok(bus.w_addr);
  assign rsv_ok = idle && bus.rsv_en && addr_ok(bus.rsv_addr);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == SWEEP && cnt_q != LAST) ? cnt_q + AW'(1) : '0;
    end
  end
  always_comb state_d = idle ? (bus.clr_req ? SWEEP : IDLE) : (cnt_q == LAST ? IDLE : SWEEP);
  // Reserve is applied after the write so a same-cycle reserve leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend <= '0;
    end else if (!idle) begin
      regs[cnt_q] <= '0;
      pend[cnt_q] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[bus.w_addr] <= bus.w_data;
        pend[bus.w_addr] <= 1'b0;
      end
      if (rsv_ok) pend[bus.rsv_addr] <= 1'b1;
    end
  end
  // wr_ok already implies IDLE, so bypass is off during a sweep.
  always_comb begin
    bus.busy    = state_q == SWEEP;
    bus.r_data1 = !addr_ok(bus.r_addr1) ? '0 :
                  (BYPASS && wr_ok && bus.w_addr == bus.r_addr1) ? bus.w_data : regs[bus.r_addr1];
    bus.r_data2 = !addr_ok(bus.r_addr2) ? '0 :
                  (BYPASS && wr_ok && bus.w_addr == bus.r_addr2) ? bus.w_data : regs[bus.r_addr2];
    bus.pend1   = addr_ok(bus.r_addr1) ? pend[bus.r_addr1] : 1'b0;
    bus.pend2   = addr_ok(bus.r_addr2) ? pend[bus.r_addr2] : 1'b0;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for two reg_file_sb configurations
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  reg_file_sb_if #(.DW(16), .AW(4)) ia ();
  reg_file_sb_if #(.DW(16), .AW(4)) ib ();
  reg_file_sb #(.DW(16), .DEPTH(16), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  reg_file_sb #(.DW(16), .DEPTH(12), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    {ia.we, ia.w_addr, ia.w_data, ia.r_addr1, ia.r_addr2, ia.rsv_en, ia.rsv_addr, ia.clr_req} = '0;
    {ib.we, ib.w_addr, ib.w_data, ib.r_addr1, ib.r_addr2, ib.rsv_en, ib.rsv_addr, ib.clr_req} = '0;
    #1;
    chk("rst_rdata1", ia.r_data1, 0);
    chk("rst_pend1", ia.pend1, 0);
    chk("rst_busy", ia.busy, 0);
    tick;
    tick;
    rst = 1'b0;
    ia.we = 1; ia.w_addr = 5; ia.w_data = 16'hBEEF; ia.r_addr1 = 5;
    #1 chk("wr_bypass_r5", ia.r_data1, 16'hBEEF);
    tick;
    ia.we = 0; ia.w_data = 16'h1234;
    #1 chk("wr_r5", ia.r_data1, 16'hBEEF);
    tick;
    chk("we0_keeps_r5", ia.r_data1, 16'hBEEF);
    ia.we = 1; ia.w_addr = 3; ia.w_data = 16'hA5A5; ia.r_addr1 = 3; ia.r_addr2 = 3;
    #1;
    chk("bypass_p1", ia.r_data1, 16'hA5A5);
    chk("bypass_p2", ia.r_data2, 16'hA5A5);
    tick;
    ia.w_addr = 0; ia.w_data = 16'hFFFF; ia.r_addr1 = 0;
    tick;
    ia.we = 0;
    #1 chk("r0_not_zeroed", ia.r_data1, 16'hFFFF);
    ia.rsv_en = 1; ia.rsv_addr = 7; ia.r_addr1 = 7;
    #1 chk("rsv_not_yet", ia.pend1, 0);
    tick;
    ia.rsv_en = 0;
    #1 chk("rsv_pend", ia.pend1, 1);
    ia.we = 1; ia.w_addr = 7; ia.w_data = 16'h7777;
    #1;
    chk("pend_not_comb_cleared", ia.pend1, 1);
    chk("bypass_r7", ia.r_data1, 16'h7777);
    tick;
    ia.we = 0;
    #1 chk("write_clears_pend", ia.pend1, 0);
    ia.we = 1; ia.w_data = 16'h1357; ia.rsv_en = 1; ia.rsv_addr = 7;
    tick;
    ia.we = 0; ia.rsv_en = 0;
    #1;
    chk("rsv_wins_pend", ia.pend1, 1);
    chk("rsv_wins_data", ia.r_data1, 16'h1357);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rdata1", ia.r_data1, 0);
    chk("midrst_pend1", ia.pend1, 0);
    chk("midrst_busy", ia.busy, 0);
    tick;
    rst = 1'b0;
    ia.we = 1;
    for (int i = 0; i < 16; i++) begin
      ia.w_addr = 4'(i); ia.w_data = 16'h0100 + 16'(i);
      tick;
    end
    ia.we = 0; ia.rsv_en = 1; ia.rsv_addr = 9;
    tick;
    ia.rsv_en = 0; ia.r_addr2 = 9;
    #1 chk("pre_sweep_pend9", ia.pend2, 1);
    ia.clr_req = 1; ia.r_addr1 = 4;
    tick;
    ia.clr_req = 0;
    chk("sweep_busy_rise", ia.busy, 1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        ia.we = 1; ia.w_addr = 12; ia.w_data = 16'hDEAD; ia.r_addr2 = 12;
        #1 chk("sweep_no_bypass", ia.r_data2, 16'h010C);
      end
      tick;
      ia.we = 0;
      #1;
      chk($sformatf("sweep_r4_k%0d", k), ia.r_data1, k >= 5 ? 0 : 16'h0104);
      chk($sformatf("sweep_busy_k%0d", k), ia.busy, k < 16 ? 1 : 0);
    end
    for (int i = 0; i < 16; i++) begin
      ia.r_addr1 = 4'(i);
      #1 chk($sformatf("swept_r%0d", i), ia.r_data1, 0);
    end
    ia.r_addr2 = 9;
    #1 chk("swept_pend9", ia.pend2, 0);
    ia.we = 1; ia.w_addr = 2; ia.w_data = 16'h2222; ia.r_addr1 = 2;
    tick;
    ia.we = 0;
    #1 chk("first_write_after_sweep", ia.r_data1, 16'h2222);
    ia.we = 1; ia.w_addr = 15; ia.w_data = 16'hF0F0;
    tick;
    ia.we = 0; ia.clr_req = 1; ia.r_addr1 = 15;
    tick;
    ia.clr_req = 0;
    for (int k = 0; k < 8; k++) tick;
    chk("abort_busy_before", ia.busy, 1);
    chk("abort_r15_before", ia.r_data1, 16'hF0F0);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", ia.busy, 0);
    chk("abort_r15", ia.r_data1, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("abort_busy_stays", ia.busy, 0);
    ib.we = 1; ib.w_addr = 3; ib.w_data = 16'h1111;
    tick;
    ib.w_data = 16'hA5A5; ib.r_addr1 = 3; ib.r_addr2 = 3;
    #1;
    chk("nobyp_p1_old", ib.r_data1, 16'h1111);
    chk("nobyp_p2_old", ib.r_data2, 16'h1111);
    tick;
    ib.we = 0;
    #1;
    chk("nobyp_p1_new", ib.r_data1, 16'hA5A5);
    chk("nobyp_p2_new", ib.r_data2, 16'hA5A5);
    ib.we = 1; ib.w_addr = 0; ib.w_data = 16'hFFFF; ib.rsv_en = 1; ib.rsv_addr = 0; ib.r_addr1 = 0;
    #1 chk("zr0_same_cycle", ib.r_data1, 0);
    tick;
    ib.we = 0; ib.rsv_en = 0;
    #1;
    chk("zr0_data", ib.r_data1, 0);
    chk("zr0_pend", ib.pend1, 0);
    ib.we = 1; ib.w_addr = 13; ib.w_data = 16'hBBBB; ib.rsv_en = 1; ib.rsv_addr = 13; ib.r_addr1 = 13;
    tick;
    ib.we = 0; ib.rsv_en = 0;
    #1;
    chk("oor_read", ib.r_data1, 0);
    chk("oor_pend", ib.pend1, 0);
    ib.r_addr1 = 1;
    #1 chk("oor_no_alias_r1", ib.r_data1, 0);
    ib.rsv_en = 1; ib.rsv_addr = 5; ib.r_addr1 = 5;
    tick;
    ib.rsv_en = 0;
    #1 chk("b_rsv_pend5", ib.pend1, 1);
    ib.we = 1; ib.w_addr = 11; ib.w_data = 16'h0B0B;
    tick;
    ib.we = 0; ib.r_addr1 = 11;
    #1 chk("b_r11_written", ib.r_data1, 16'h0B0B);
    ib.clr_req = 1;
    tick;
    ib.clr_req = 0;
    n = 0;
    while (ib.busy && n < 40) begin
      tick;
      n++;
    end
    chk("b_sweep_len", n, 12);
    chk("b_r11_swept", ib.r_data1, 0);
    ib.r_addr1 = 5;
    #1 chk("b_pend5_swept", ib.pend1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with the same access model as the current register file: one synchronous write port and two combinational read ports. It adds honoured write enable, asynchronous reset, optional hardwired-zero R0, write-to-read bypass, a per-register pending scoreboard for the issue stage, and a multi-cycle clear sequencer. It sits between decode/issue and the ALU.

## Interface
- DW, 16, data width in bits
- DEPTH, 16, number of registers (≥2, need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; not overridden)
- ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, never pending
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- w_addr  in  AW  write address
- w_data  in  DW  write data
- r_addr1  in  AW  read address, port 1
- r_addr2  in  AW  read address, port 2
- r_data1  out  DW  read data, port 1 (combinational)
- r_data2  out  DW  read data, port 2 (combinational)
- rsv_en  in  1  reserve request: set pending bit of rsv_addr
- rsv_addr  in  AW  register to reserve
- pend1  out  1  pending bit of r_addr1 (combinational from flops)
- pend2  out  1  pending bit of r_addr2
- clr_req  in  1  start clear sweep (pulse or level; sampled in IDLE only)
- busy  out  1  clear sweep in progress

## Operation
- Reset (async, immediate): all registers = 0, all pending bits = 0, FSM = IDLE, sweep counter = 0, busy = 0. Outputs therefore read 0 and pend1/pend2 read 0 while rst is high.
- Write: on a rising edge with we=1, FSM=IDLE and w_addr<DEPTH, reg[w_addr] <= w_data and pend[w_addr] <= 0. When we=0 nothing is written.
- Out-of-range addresses (≥DEPTH) are ignored: writes and reserves are dropped, reads return 0, pend returns 0.
- ZERO_R0=1: address 0 reads 0, writes to it and reserves of it are dropped, and pend for it is 0.
- Read: r_dataN = reg[r_addrN]. If BYPASS=1, FSM=IDLE, we=1 and w_addr==r_addrN (valid, not a zeroed R0), then r_dataN = w_data. Both ports are independent and may use the same address.
- Scoreboard: rsv_en=1 in IDLE sets pend[rsv_addr] at the edge. If a write and a reserve target the same address in the same cycle, the reserve wins and pend ends at 1. pendN reflects registered pend bits only; a same-cycle write does not clear pendN combinationally.
- Clear FSM, IDLE/SWEEP:
  - IDLE → SWEEP when clr_req=1, with cnt <= 0.
  - SWEEP: each edge sets reg[cnt] <= 0, pend[cnt] <= 0, cnt <= cnt+1. When cnt==DEPTH-1, the FSM returns to IDLE and cnt <= 0.
  - busy = (FSM==SWEEP).
  - During SWEEP, we, rsv_en and clr_req are ignored (dropped, not queued), bypass is disabled, and reads return current array contents, so partially cleared state is visible.
- A reset asserted mid-sweep aborts the sweep: the FSM goes to IDLE and all state is zeroed.

## Timing
- Write latency: data is visible via the array 1 cycle after the write edge. With BYPASS=1 it is visible combinationally in the write cycle.
- Reserve latency: pend visible 1 cycle after the rsv_en edge.
- Clear: busy rises 1 cycle after clr_req is sampled and stays high for exactly DEPTH cycles. The first accepted write is on the edge after busy falls (busy=0 at the sampling edge).
- No combinational path from rst to outputs other than through async-cleared flops.

## Test plan
- Reset/basic: assert rst mid-run → r_data1/2=0, pend1/2=0, busy=0. Write 0xBEEF to R5, we=1 → next cycle r_addr1=5 gives 0xBEEF. we=0 with 0x1234 → R5 stays 0xBEEF.
- Bypass: BYPASS=1, write 0xA5A5 to R3 while r_addr1=r_addr2=3 → both read 0xA5A5 in the same cycle. BYPASS=0 → old value that cycle, 0xA5A5 the next.
- Zero R0: ZERO_R0=1, write 0xFFFF to R0 and reserve R0 → r_data=0 and pend=0 always. ZERO_R0=0 → reads 0xFFFF.
- Scoreboard: reserve R7 → pend1=1 (r_addr1=7) next cycle. Write R7 → pend1=0 next cycle. Reserve and write R7 in the same cycle → pend1=1 and data updated.
- Clear sweep: fill R0..R15 with 0x0100+i, pulse clr_req → busy high 16 cycles, R4 reads 0 after the 5th sweep edge, a write during busy is dropped, all registers read 0 when busy falls. Assert rst at sweep cycle 8 → busy=0 immediately and all registers 0.
- Non-power-of-two: DEPTH=12 → a write to address 13 is dropped, a read of 13 returns 0, and the sweep lasts 12 cycles.
